fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum words accepted per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester write request; level, held until acked.
REQ-007 SHALL have port req_data  input  N_REQ*WIDTH  packed requester data; slice i belongs to req[i].
REQ-008 SHALL have port ack  output  N_REQ  one-hot word-accepted strobe, combinational.
REQ-009 SHALL have port grant  output  N_REQ  one-hot registered ownership; all-zero when idle.
REQ-010 SHALL have port fifo_wr_en  output  1  write strobe to the shared sync FIFO.
REQ-011 SHALL have port fifo_data  output  WIDTH  data of the granted requester.
REQ-012 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-013 SHALL have port fifo_full_th  input  1  FIFO full-watermark flag.

Function
REQ-014 SHALL implement states IDLE and BURST, state register reset to IDLE.
REQ-015 SHALL, in IDLE with any req set, pick a winner by round-robin starting at rr_ptr, assert its grant next cycle, and enter BURST.
REQ-016 SHALL drive ack[i] = grant[i] & req[i] & !fifo_full, fifo_wr_en = |ack, fifo_data = req_data slice of the granted index (zero when no grant).
REQ-017 SHALL count accepted words in a burst counter, cleared on grant.
REQ-018 SHALL end the burst on the cycle of the ack that makes the count reach BURST_MAX, or when the granted req is low, or on the cycle of any ack while fifo_full_th is high (throttle to one word per grant).
REQ-019 SHALL, at burst end, set rr_ptr to granted index + 1 modulo N_REQ, and either re-arbitrate and grant the next winner on the following cycle (back-to-back) or drop grant and return to IDLE if no req remains.
REQ-020 SHALL hold grant and the burst counter unchanged while fifo_full is high; no timeout.
REQ-021 SHALL never write to the FIFO when fifo_full is high, and never assert more than one ack or grant bit.
REQ-022 SHALL ignore req bits that rise or fall for non-granted requesters until the next arbitration.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-burst, clear grant, burst counter and rr_ptr to 0 and state to IDLE immediately; ack and fifo_wr_en therefore 0, fifo_data 0.
REQ-024 SHALL begin arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with FIFO_WR_ARB_PRIO_EN defined, give requester 0 strict priority at every arbitration point (rr_ptr ignored when req[0] set); without it, pure round-robin with all requesters equal.

Structure
REQ-026 SHALL place the state enum (IDLE, BURST) and default parameter constants in shared package fifo_arb_pkg.
REQ-027 SHALL implement winner selection in sub-module rr_pick (rotating priority encoder: req vector, pointer -> one-hot winner, valid).

Verification
REQ-028 Single requester: req=0001 held, FIFO never full, BURST_MAX=4 -> grant=0001 one cycle after req, 4 consecutive acks, burst ends, immediate re-grant of requester 0.
REQ-029 All four req high continuously -> grants cycle 0,1,2,3,0 with 4 writes each, fifo_data matches owner's slice.
REQ-030 fifo_full high 3 cycles mid-burst after 2 words -> no ack/fifo_wr_en for 3 cycles, grant held, remaining 2 words written after release.
REQ-031 fifo_full_th high, req=0011 -> exactly one word per grant, alternating 0,1.
REQ-032 rst_n low during word 3 of a burst -> grant=0, fifo_wr_en=0 same cycle; after release req=0100 -> grant=0100 next cycle with rr_ptr from 0.
REQ-033 FIFO_WR_ARB_PRIO_EN defined, req=1111 -> requester 0 granted at every arbitration point; undefined -> REQ-029 ordering.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_BURST_MAX = 4;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating priority encoder: first set req at or after ptr (wrapping) wins.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_win;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot     = N'({req, req} >> ptr);
    rot_win = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    winner  = N'(({rot_win, rot_win} << ptr) >> N);
    valid   = |req;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-limited round-robin arbiter feeding one shared sync FIFO write port.
// Define FIFO_WR_ARB_PRIO_EN to give requester 0 strict priority.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       grant,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_data,
  input  logic                   fifo_full,
  input  logic                   fifo_full_th
);

  localparam int unsigned      PTR_W    = ptr_width(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pick_win, sel_win;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PTR_W-1:0] ptr_q, ptr_d, gidx, next_ptr, pick_ptr;
  logic             pick_valid, ack_any, req_gnt, burst_end;

  // At a burst end the pointer used for re-arbitration is the one being
  // written this cycle, so back-to-back grants already see the rotation.
  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    ack        = grant_q & req & {N_REQ{~fifo_full}};
    ack_any    = |ack;
    req_gnt    = |(grant_q & req);
    fifo_wr_en = ack_any;
    fifo_data  = '0;
    gidx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        fifo_data = fifo_data | req_data[i*WIDTH +: WIDTH];
        gidx      = gidx | PTR_W'(i);
      end
    end
    next_ptr  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    pick_ptr  = (state_q == BURST) ? next_ptr : ptr_q;
    cnt_inc   = cnt_q + 1'b1;
    burst_end = (state_q == BURST) &&
                (!req_gnt || (ack_any && ((cnt_inc == CNT_LAST) || fifo_full_th)));
  end

  always_comb begin
`ifdef FIFO_WR_ARB_PRIO_EN
    sel_win = req[0] ? N_REQ'(1) : pick_win;
`else
    sel_win = pick_win;
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = sel_win;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (burst_end) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_valid) begin
            grant_d = sel_win;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (ack_any) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: vector table plus hand-written corner sequences.
module tb_fifo_wr_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic           fifo_full;
  logic           fifo_full_th;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .N_REQ     (N),
    .WIDTH     (W),
    .BURST_MAX (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .grant        (grant),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data    (fifo_data),
    .fifo_full    (fifo_full),
    .fifo_full_th (fifo_full_th)
  );

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic         th;
    int unsigned  nwr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_one(input int unsigned idx);
    exp_t e;
    e.ack      = '0;
    e.ack[idx] = 1'b1;
    e.data     = req_data[idx*W +: W];
    sb.push_back(e);
  endtask

  // Expected write order for a constant req pattern starting from a reset pointer.
  task automatic gen_expected(input logic [N-1:0] r, input logic th, input int unsigned nwr);
    int unsigned ptr, pushed, owner, blen;
    logic found;
    ptr = 0;
    pushed = 0;
    blen = th ? 1 : 4;
    while (pushed < nwr) begin
      owner = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && r[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          found = 1'b1;
        end
      end
`ifdef FIFO_WR_ARB_PRIO_EN
      if (r[0]) owner = 0;
`endif
      for (int unsigned j = 0; j < blen && pushed < nwr; j++) begin
        push_one(owner);
        pushed++;
      end
      ptr = (owner + 1) % N;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write ack=%b data=%h at %0t", ack, fifo_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ack", 32'(ack), 32'(e.ack));
        check("sb_data", 32'(fifo_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    fifo_full_th = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_first;
    vecs[0] = '{req: 4'b0001, th: 1'b0, nwr: 8};
    vecs[1] = '{req: 4'b1111, th: 1'b0, nwr: 20};
    vecs[2] = '{req: 4'b0011, th: 1'b1, nwr: 6};
    vecs[3] = '{req: 4'b1010, th: 1'b0, nwr: 12};
    vecs[4] = '{req: 4'b0110, th: 1'b1, nwr: 5};
    vecs[5] = '{req: 4'b1000, th: 1'b1, nwr: 3};

    rst_n = 1'b0;
    req = 4'b1111;
    req_data = 32'hA5C3_7E19;
    fifo_full = 1'b0;
    fifo_full_th = 1'b0;
    tick();
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_data", 32'(fifo_data), 32'h0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      req_data = $urandom | 32'h0101_0101;
      gen_expected(vecs[v].req, vecs[v].th, vecs[v].nwr);
      exp_first = sb[0].ack;
      fifo_full_th = vecs[v].th;
      req = vecs[v].req;
      @(negedge clk);
      check("vec_grant_before", 32'(grant), 32'h0);
      tick();
      @(negedge clk);
      check("vec_first_grant", 32'(grant), 32'(exp_first));
      repeat (vecs[v].nwr) tick();
      check("vec_drained", 32'(sb.size()), 32'h0);
      req = '0;
      fifo_full_th = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("vec_idle_grant", 32'(grant), 32'h0);
      check("vec_idle_data", 32'(fifo_data), 32'h0);
    end

    // fifo_full for 3 cycles after 2 words: grant and count frozen.
    do_reset();
    req_data = 32'h4433_2211;
    repeat (4) push_one(0);
    req = 4'b0011;
    tick();
    tick();
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_wr_en", 32'(fifo_wr_en), 32'h0);
      check("full_ack", 32'(ack), 32'h0);
      check("full_grant", 32'(grant), 32'h1);
      tick();
    end
    fifo_full = 1'b0;
    tick();
    tick();
    req = '0;
    @(negedge clk);
`ifdef FIFO_WR_ARB_PRIO_EN
    check("full_next_grant", 32'(grant), 32'h1);
`else
    check("full_next_grant", 32'(grant), 32'h2);
`endif
    check("full_drained", 32'(sb.size()), 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("full_idle_grant", 32'(grant), 32'h0);

    // Reset during word 3 of the second burst, then pointer must restart at 0.
    do_reset();
    req_data = 32'h8877_6655;
    repeat (4) push_one(0);
`ifdef FIFO_WR_ARB_PRIO_EN
    repeat (2) push_one(0);
`else
    repeat (2) push_one(1);
`endif
    req = 4'b0011;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("mid_rst_data", 32'(fifo_data), 32'h0);
    check("mid_rst_drained", 32'(sb.size()), 32'h0);
    req = 4'b0101;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant0", 32'(grant), 32'h0);
    push_one(0);
    tick();
    @(negedge clk);
    check("post_rst_grant", 32'(grant), 32'h1);
    tick();
    req = '0;
    check("post_rst_drained", 32'(sb.size()), 32'h0);

    // Single requester 2 right after reset release.
    do_reset();
    req_data = 32'h00C0_0000;
    req = 4'b0100;
    @(negedge clk);
    check("req2_grant_before", 32'(grant), 32'h0);
    push_one(2);
    tick();
    @(negedge clk);
    check("req2_grant", 32'(grant), 32'h4);
    tick();
    req = '0;
    tick();
    tick();
    @(negedge clk);
    check("req2_drained", 32'(sb.size()), 32'h0);
    check("req2_idle_grant", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
